// File: rtl/duft_seq_ctrl.sv
// duft_seq_ctrl: expands host DUT-run / DFT-scan commands into DUFT ap_ctrl_hs
// bus transactions and streams read-back words to the host over valid/ready.
module duft_seq_ctrl #(
    parameter int unsigned DUMP_NBR   = 1,
    parameter int unsigned MAX_CYCLES = 16,
    parameter int unsigned POLL_MAX   = 64,
    parameter int unsigned TIMEOUT    = 200
) (
    input  logic        clk,
    input  logic        ap_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_mode,
    input  logic [31:0] cmd_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [7:0]  res_tag,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] addr,
    output logic [31:0] wr_data,
    output logic        rd_wr,
    output logic        ap_start,
    input  logic        ap_idle,
    input  logic        ap_ready,
    input  logic        ap_done,
    input  logic [31:0] ap_return
);

    typedef enum logic [1:0] {BIdle, BWaitIdle, BWaitDone} bus_st_e;
    typedef enum logic [3:0] {
        MIdle, MWrIn, MOpWr, MOpNone, MOpPoll, MRdOut, MRdDump, MRdState, MEmit
    } main_st_e;
    typedef enum logic [2:0] {PhInput, PhRun, PhEndr, PhTest, PhNext, PhEndt} phase_e;

    bus_st_e     bus_st_q, bus_st_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] addr_q, addr_d, wr_data_q, wr_data_d, rdata_q, rdata_d;
    logic        rd_wr_q, rd_wr_d, ap_start_q, ap_start_d;
    logic        bus_done_q, bus_done_d, bus_err_q, bus_err_d;

    main_st_e    st_q, st_d;
    phase_e      ph_q, ph_d;
    logic        mode_q, mode_d, cmd_ready_q, cmd_ready_d;
    logic [31:0] data_q, data_d, res_data_q, res_data_d;
    logic [7:0]  cycle_q, cycle_d, res_tag_q, res_tag_d;
    logic [2:0]  dump_q, dump_d;
    logic [15:0] poll_q, poll_d;
    logic        done_q, done_d, err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic        bus_req, req_rd;
    logic [31:0] req_addr, req_wdata, op_x;
    logic [3:0]  op_s;

    // ap_ready is reserved by the DUFT interface and not needed here.
    logic unused_ap_ready;
    assign unused_ap_ready = ap_ready;

    // Opcode to issue and STATE value to poll for in the current phase.
    always_comb begin
        op_x = 32'd0;
        op_s = 4'd0;
        unique case (ph_q)
            PhInput: begin op_x = 32'd1; op_s = 4'd3; end
            PhRun:   begin op_x = 32'd2; op_s = 4'd5; end
            PhEndr:  begin op_x = 32'd3; op_s = 4'd0; end
            PhTest:  begin op_x = 32'd4; op_s = 4'd9; end
            PhNext:  begin op_x = 32'd5; op_s = 4'd9; end
            PhEndt:  begin op_x = 32'd6; op_s = 4'd0; end
            default: ;
        endcase
    end

    // Bus request: one per bus-phase state, issued only once the engine has
    // spent a cycle idle after the previous transaction.
    always_comb begin
        req_rd    = 1'b1;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        bus_req   = (bus_st_q == BIdle) && !bus_done_q && !bus_err_q;
        unique case (st_q)
            MWrIn:    begin req_rd = 1'b0; req_addr = 32'h10; req_wdata = data_q; end
            MOpWr:    begin req_rd = 1'b0; req_addr = 32'h0;  req_wdata = op_x;   end
            MOpNone:  begin req_rd = 1'b0; req_addr = 32'h0;  end
            MOpPoll:  req_addr = 32'h1;
            MRdOut:   req_addr = 32'h18;
            MRdDump:  req_addr = 32'h20 + {29'd0, dump_q};
            MRdState: req_addr = 32'h1;
            default:  bus_req = 1'b0;
        endcase
    end

    // Bus engine: drive address, wait ap_idle, start, wait ap_done, park the bus.
    always_comb begin
        bus_st_d   = bus_st_q;
        tmo_d      = tmo_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        rd_wr_d    = rd_wr_q;
        ap_start_d = ap_start_q;
        rdata_d    = rdata_q;
        bus_done_d = 1'b0;
        bus_err_d  = 1'b0;
        unique case (bus_st_q)
            BIdle: begin
                if (bus_req) begin
                    bus_st_d  = BWaitIdle;
                    addr_d    = req_addr;
                    wr_data_d = req_wdata;
                    rd_wr_d   = req_rd;
                    tmo_d     = '0;
                end
            end
            BWaitIdle, BWaitDone: begin
                if (bus_st_q == BWaitIdle && ap_idle) begin
                    ap_start_d = 1'b1;
                    tmo_d      = '0;
                    bus_st_d   = BWaitDone;
                end else if (bus_st_q == BWaitDone && ap_done) begin
                    rdata_d    = ap_return;
                    bus_done_d = 1'b1;
                    ap_start_d = 1'b0;
                    addr_d     = '1;
                    bus_st_d   = BIdle;
                end else if (tmo_q == 16'(TIMEOUT - 1)) begin
                    bus_err_d  = 1'b1;
                    ap_start_d = 1'b0;
                    addr_d     = '1;
                    bus_st_d   = BIdle;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: bus_st_d = BIdle;
        endcase
    end

    // Command sequencer: steps through the op/poll/read plan on each bus completion.
    always_comb begin
        st_d       = st_q;
        ph_d       = ph_q;
        mode_d     = mode_q;
        data_d     = data_q;
        cycle_d    = cycle_q;
        dump_d     = dump_q;
        poll_d     = poll_q;
        res_data_d = res_data_q;
        res_tag_d  = res_tag_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        if (bus_err_q) begin
            st_d = MIdle; done_d = 1'b1; err_d = 1'b1; err_code_d = 2'd1;
        end else begin
            unique case (st_q)
                MIdle: begin
                    if (cmd_valid && cmd_ready_q) begin
                        mode_d = cmd_mode; data_d = cmd_data; err_code_d = 2'd0;
                        cycle_d = '0; ph_d = PhInput; st_d = MWrIn;
                    end
                end
                MWrIn:   if (bus_done_q) st_d = MOpWr;
                MOpWr:   if (bus_done_q) st_d = MOpNone;
                MOpNone: if (bus_done_q) begin st_d = MOpPoll; poll_d = '0; end
                MOpPoll: begin
                    if (bus_done_q) begin
                        if (rdata_q[3:0] == op_s) begin
                            unique case (ph_q)
                                PhInput: begin ph_d = mode_q ? PhTest : PhRun; st_d = MOpWr; end
                                PhRun:   begin ph_d = PhEndr; st_d = MOpWr; end
                                PhEndr:  st_d = MRdOut;
                                PhEndt:  begin st_d = MIdle; done_d = 1'b1; end
                                default: begin st_d = MRdDump; dump_d = '0; end
                            endcase
                        end else if (poll_q == 16'(POLL_MAX - 1)) begin
                            st_d = MIdle; done_d = 1'b1; err_d = 1'b1; err_code_d = 2'd2;
                        end else begin
                            poll_d = poll_q + 16'd1;
                        end
                    end
                end
                MRdOut: begin
                    if (bus_done_q) begin res_data_d = rdata_q; res_tag_d = '0; st_d = MEmit; end
                end
                MRdDump: begin
                    if (bus_done_q) begin
                        res_data_d = rdata_q; res_tag_d = {cycle_q[4:0], dump_q}; st_d = MEmit;
                    end
                end
                MEmit: begin
                    if (res_ready) begin
                        if (!mode_q) begin
                            st_d = MIdle; done_d = 1'b1;
                        end else if (dump_q == 3'(DUMP_NBR - 1)) begin
                            st_d = MRdState;
                        end else begin
                            dump_d = dump_q + 3'd1; st_d = MRdDump;
                        end
                    end
                end
                MRdState: begin
                    if (bus_done_q) begin
                        // bit 5 is the DUFT's dut_op_commit flag
                        if (rdata_q[5] && rdata_q[3:0] == 4'd9) begin
                            ph_d = PhEndt; st_d = MOpWr;
                        end else if ((cycle_q + 8'd1) == 8'(MAX_CYCLES)) begin
                            st_d = MIdle; done_d = 1'b1; err_d = 1'b1; err_code_d = 2'd3;
                        end else begin
                            cycle_d = cycle_q + 8'd1; ph_d = PhNext; st_d = MOpWr;
                        end
                    end
                end
                default: st_d = MIdle;
            endcase
        end
        cmd_ready_d = (st_d == MIdle);
    end

    // State registers.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            bus_st_q   <= BIdle;      tmo_q      <= '0;
            addr_q     <= '1;         wr_data_q  <= '0;
            rd_wr_q    <= 1'b1;       ap_start_q <= 1'b0;
            rdata_q    <= '0;         bus_done_q <= 1'b0;
            bus_err_q  <= 1'b0;       st_q       <= MIdle;
            ph_q       <= PhInput;    mode_q     <= 1'b0;
            data_q     <= '0;         cycle_q    <= '0;
            dump_q     <= '0;         poll_q     <= '0;
            res_data_q <= '0;         res_tag_q  <= '0;
            done_q     <= 1'b0;       err_q      <= 1'b0;
            err_code_q <= '0;         cmd_ready_q <= 1'b0;
        end else begin
            bus_st_q   <= bus_st_d;   tmo_q      <= tmo_d;
            addr_q     <= addr_d;     wr_data_q  <= wr_data_d;
            rd_wr_q    <= rd_wr_d;    ap_start_q <= ap_start_d;
            rdata_q    <= rdata_d;    bus_done_q <= bus_done_d;
            bus_err_q  <= bus_err_d;  st_q       <= st_d;
            ph_q       <= ph_d;       mode_q     <= mode_d;
            data_q     <= data_d;     cycle_q    <= cycle_d;
            dump_q     <= dump_d;     poll_q     <= poll_d;
            res_data_q <= res_data_d; res_tag_q  <= res_tag_d;
            done_q     <= done_d;     err_q      <= err_d;
            err_code_q <= err_code_d; cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign res_valid = (st_q == MEmit);
    assign res_data  = res_data_q;
    assign res_tag   = res_tag_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign rd_wr     = rd_wr_q;
    assign ap_start  = ap_start_q;

endmodule
